led_pwm_driver: RTL and testbench
=================================

Name: led_pwm_driver

Overview:
- Output-side counterpart to the board input conditioning: drives the RGB LED pins from the femto GPIO outputs with per-channel brightness (PWM) and an optional blink gate.
- Sits in the FPGA wrapper between femto gpio[3:1] and led_r/led_g/led_b.
- Produces registered, glitch-free pin levels. Duty updates take effect only at PWM period boundaries.

Parameters:
- CHANNELS, 3, number of LED channels (index 0=r, 1=g, 2=b).
- DUTY_W, 8, duty resolution; PWM period is 2^DUTY_W ticks.
- PRESCALE, 64, clk cycles per PWM tick (>=1).
- BLINK_PERIODS, 128, PWM periods per blink half-phase (>=1).
- ACTIVE_LOW, 0, 1 inverts pin polarity for common-anode LEDs.

Ports:
- clk  input  1  system clock, the single clock domain.
- rstn  input  1  synchronous active-low reset, sampled on posedge clk.
- en  input  CHANNELS  per-channel enable from gpio; level, already synchronous.
- blink_en  input  1  1 = gate all outputs with the blink phase.
- cfg_we  input  1  duty write strobe, one cycle.
- cfg_sel  input  2  channel index for the write; values >= CHANNELS are ignored.
- cfg_duty  input  DUTY_W  new duty value.
- period_end  output  1  one-cycle pulse on the last tick of each PWM period.
- led  output  CHANNELS  pin drive, registered.

Behaviour:
- Reset (rstn=0 at posedge): prescaler=0, pwm_cnt=0, blink_cnt=0, blink_phase=1 (on), shadow and active duty=0, period_end=0, led = all ACTIVE_LOW (LED dark). Reset asserted mid-period aborts the period; nothing is retained.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 in the cycle it equals PRESCALE-1. If PRESCALE=1, tick=1 every cycle.
- pwm_cnt: DUTY_W bits, increments on tick, wraps from 2^DUTY_W-1 to 0.
- Period end: combinational pend = tick & (pwm_cnt == all-ones). The period_end output is pend registered, so it is high during the cycle after the wrap.
- Config handshake:
  - No backpressure; writes are always accepted.
  - cfg_we=1 with a valid cfg_sel loads shadow[cfg_sel] <= cfg_duty. The last write before a boundary wins.
  - At pend, active[i] <= shadow[i] for all i.
  - A write coinciding with pend bypasses the shadow: active[cfg_sel] gets cfg_duty that cycle, and shadow is updated too.
- Compare (per channel): on = (active == all-ones) | (pwm_cnt < active).
  - duty 0 gives always dark.
  - duty k gives k/2^DUTY_W on-time.
  - duty all-ones gives a constant on level, with no one-tick gap.
- Blink:
  - blink_cnt counts pend events 0..BLINK_PERIODS-1.
  - At the wrap, blink_phase toggles.
  - When blink_en=0, blink_cnt and blink_phase are held at 0 and 1; re-enabling starts from phase on.
- Output: led[i] <= (en[i] & on[i] & (blink_phase | ~blink_en)) ^ ACTIVE_LOW.
  - Latency is one clk from en, blink_en or pwm_cnt change to pin.
  - en deassertion darkens the pin on the next clk edge, not at the period boundary.
- All counters free-run regardless of en.

Decomposition:
- Package led_pkg:
  - DUTY_FULL constant (all-ones).
  - LED channel index constants LED_R=0, LED_G=1, LED_B=2.
- Sub-module led_pwm_channel:
  - Contains shadow/active duty registers, bypass logic, the compare, and the output flop.
  - Instantiated CHANNELS times.
  - Prescaler, pwm_cnt, and blink logic stay shared in the top.

Test Plan (PRESCALE=1, DUTY_W=4, BLINK_PERIODS=2, ACTIVE_LOW=0):
- Reset check: hold rstn=0 for 3 cycles with en=3'b111 and duty writes pending, then release. Required: led=000 throughout reset and after; the first period_end pulse occurs 16 cycles after the reset release edge.
- Duty 4 on r: write cfg_sel=0, cfg_duty=4, with en[0]=1. Required: led[0]=0 until the next period_end, then high for exactly 4 of every 16 cycles; g and b stay 0.
- Full and zero duty: duty=15 on g gives led[1] constantly 1 across 3 periods. Duty=0 gives led[1] constantly 0.
- Boundary write:
  - Write duty=8 in the same cycle as pend. Required: 8/16 from the immediately following period.
  - Two writes (3, then 9) inside one period. Required: 9/16 next period.
  - cfg_sel=3 changes nothing.
- Blink: duty=15 on b, blink_en=1. Required: led[2] is on for 32 cycles, off for 32, repeating. Dropping blink_en restores on within 1 cycle.
- Reset mid-operation: assert rstn=0 at pwm_cnt=7 with duty 4 active. Required: led=000 next edge; active duty reads back 0 (no light) after release until a new write plus a boundary.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared constants for the LED PWM driver.
//   DUTY_FULL   all-ones duty pattern; slice [DUTY_W-1:0] for the width in use
//   LED_R/G/B   channel indices into en/led
package led_pkg;

    localparam logic [31:0] DUTY_FULL = 32'hFFFF_FFFF;

    localparam int LED_R = 0;
    localparam int LED_G = 1;
    localparam int LED_B = 2;

endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel with double-buffered duty, PWM compare and
// a registered pin driver.
//   clk, rstn   system clock, synchronous active-low reset
//   en          channel enable (level)
//   gate        blink gate from the top (1 = allowed to light)
//   pend        last tick of the PWM period (shadow -> active transfer)
//   wr          duty write strobe already decoded for this channel
//   cfg_duty    duty value for the write
//   pwm_cnt     shared PWM counter
//   led         registered pin level
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int DUTY_W     = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              gate,
    input  logic              pend,
    input  logic              wr,
    input  logic [DUTY_W-1:0] cfg_duty,
    input  logic [DUTY_W-1:0] pwm_cnt,
    output logic              led
);

    localparam logic [DUTY_W-1:0] FULL = DUTY_FULL[DUTY_W-1:0];
    localparam logic              POL  = (ACTIVE_LOW != 0);

    logic [DUTY_W-1:0] shadow_q, shadow_d;
    logic [DUTY_W-1:0] active_q, active_d;
    logic              led_q, led_d;
    logic              on;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr) begin
            shadow_d = cfg_duty;
        end
        // A write landing on the boundary goes straight to active so it is
        // not lost for a whole period.
        if (pend) begin
            active_d = wr ? cfg_duty : shadow_q;
        end
    end

    // Full scale is special-cased so the pin never drops for the one tick
    // where pwm_cnt equals all-ones.
    assign on = (active_q == FULL) || (pwm_cnt < active_q);

    always_comb begin
        led_d = (en & on & gate) ^ POL;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shadow_q <= '0;
            active_q <= '0;
            led_q    <= POL;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: drives the RGB LED pins from the GPIO enables with
// per-channel PWM brightness and an optional common blink gate.
//   clk, rstn   system clock, synchronous active-low reset
//   en          per-channel enable
//   blink_en    1 = gate all channels with the blink phase
//   cfg_we      duty write strobe
//   cfg_sel     channel for the write (out-of-range values ignored)
//   cfg_duty    new duty value (takes effect at the next period boundary)
//   period_end  one-cycle pulse, registered, after each PWM period wraps
//   led         registered pin levels
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int CHANNELS      = 3,
    parameter int DUTY_W        = 8,
    parameter int PRESCALE      = 64,
    parameter int BLINK_PERIODS = 128,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [CHANNELS-1:0] en,
    input  logic                blink_en,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_sel,
    input  logic [DUTY_W-1:0]   cfg_duty,
    output logic                period_end,
    output logic [CHANNELS-1:0] led
);

    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BLINK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_PERIODS - 1);
    localparam logic [DUTY_W-1:0]  FULL      = DUTY_FULL[DUTY_W-1:0];

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               period_end_q, period_end_d;
    logic               tick;
    logic               pend;
    logic               gate;

    // With PRESCALE=1 the prescaler is stuck at 0 == PRESC_MAX, so tick is
    // high every cycle.
    assign tick = (presc_q == PRESC_MAX);
    assign pend = tick && (pwm_cnt_q == FULL);
    assign gate = blink_phase_q | ~blink_en;

    always_comb begin
        presc_d       = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d     = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        period_end_d  = pend;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!blink_en) begin
            // Held so that re-enabling always starts a full on half-phase.
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (pend) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            presc_q       <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            period_end_q  <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            period_end_q  <= period_end_d;
        end
    end

    assign period_end = period_end_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic wr;
        assign wr = cfg_we && (int'(cfg_sel) == i);

        led_pwm_channel #(
            .DUTY_W     (DUTY_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk      (clk),
            .rstn     (rstn),
            .en       (en[i]),
            .gate     (gate),
            .pend     (pend),
            .wr       (wr),
            .cfg_duty (cfg_duty),
            .pwm_cnt  (pwm_cnt_q),
            .led      (led[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
module tb_led_pwm_driver;
    import led_pkg::*;

    localparam int CH = 3;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [CH-1:0] en;
    logic          blink_en;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [DW-1:0] cfg_duty;
    logic          period_end;
    logic [CH-1:0] led;

    int errors = 0;
    int checks = 0;

    led_pwm_driver #(
        .CHANNELS      (CH),
        .DUTY_W        (DW),
        .PRESCALE      (1),
        .BLINK_PERIODS (2),
        .ACTIVE_LOW    (0)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .blink_en   (blink_en),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_duty   (cfg_duty),
        .period_end (period_end),
        .led        (led)
    );

    always #5 clk = ~clk;

    // Inputs change on negedge, outputs are sampled on negedge.
    task automatic do_write(input logic [1:0] sel, input logic [DW-1:0] duty);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_duty = duty;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_pe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (period_end) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_on(input int n, output int c_r, output int c_g, output int c_b);
        c_r = 0; c_g = 0; c_b = 0;
        repeat (n) begin
            @(negedge clk);
            if (led[LED_R]) c_r++;
            if (led[LED_G]) c_g++;
            if (led[LED_B]) c_b++;
        end
    endtask

    task automatic sync_pe(input string name);
        bit ok;
        wait_pe(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: period_end timeout, got 0 required 1", name);
        end
    endtask

    task automatic test_reset();
        int n;
        bit lit;
        rstn     = 1'b0;
        en       = 3'b111;
        blink_en = 1'b0;
        cfg_we   = 1'b1;
        cfg_sel  = 2'd0;
        cfg_duty = 4'd15;
        lit = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (led !== 3'b000 || period_end !== 1'b0) lit = 1'b1;
        end
        checks++;
        if (lit) begin
            errors++;
            $display("FAIL reset_hold: led=%b pe=%b required 000/0", led, period_end);
        end
        rstn   = 1'b1;
        cfg_we = 1'b0;
        n = 0;
        lit = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (led !== 3'b000) lit = 1'b1;
            if (period_end) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL reset_first_pe: after %0d cycles required 16", n);
        end
        checks++;
        if (lit) begin
            errors++;
            $display("FAIL reset_dark: led lit before first period_end, required 000");
        end
        @(negedge clk);
        checks++;
        if (period_end !== 1'b0) begin
            errors++;
            $display("FAIL pe_width: period_end=%b in second cycle required 0", period_end);
        end
        begin
            int r, g, b;
            count_on(16, r, g, b);
            checks++;
            if (r + g + b !== 0) begin
                errors++;
                $display("FAIL reset_no_retain: on-count %0d required 0", r + g + b);
            end
        end
    endtask

    task automatic test_duty_r();
        int r, g, b;
        bit ok, lit;
        do_write(2'd0, 4'd4);
        ok = 1'b0; lit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (led[LED_R]) lit = 1'b1;
            if (period_end) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || lit) begin
            errors++;
            $display("FAIL duty_r_pre: ok=%b lit=%b required 1/0", ok, lit);
        end
        count_on(32, r, g, b);
        checks++;
        if (r !== 8 || g !== 0 || b !== 0) begin
            errors++;
            $display("FAIL duty_r: counts r=%0d g=%0d b=%0d required 8/0/0", r, g, b);
        end
    endtask

    task automatic test_full_zero();
        int r, g, b;
        do_write(2'd1, 4'd15);
        sync_pe("full_sync");
        count_on(48, r, g, b);
        checks++;
        if (g !== 48 || r !== 12) begin
            errors++;
            $display("FAIL duty_full: g=%0d r=%0d required 48/12", g, r);
        end
        do_write(2'd1, 4'd0);
        sync_pe("zero_sync");
        count_on(48, r, g, b);
        checks++;
        if (g !== 0) begin
            errors++;
            $display("FAIL duty_zero: g=%0d required 0", g);
        end
    endtask

    task automatic test_boundary();
        int r, g, b;
        sync_pe("bnd_sync");
        repeat (15) @(negedge clk);
        // pwm_cnt is 15 here: this write coincides with pend
        cfg_we   = 1'b1;
        cfg_sel  = 2'd1;
        cfg_duty = 4'd8;
        @(negedge clk);
        cfg_we   = 1'b0;
        checks++;
        if (period_end !== 1'b1) begin
            errors++;
            $display("FAIL bnd_align: period_end=%b required 1", period_end);
        end
        count_on(16, r, g, b);
        checks++;
        if (g !== 8) begin
            errors++;
            $display("FAIL bnd_bypass: g=%0d required 8", g);
        end

        do_write(2'd1, 4'd3);
        repeat (2) @(negedge clk);
        do_write(2'd1, 4'd9);
        sync_pe("two_wr_sync");
        count_on(16, r, g, b);
        checks++;
        if (g !== 9) begin
            errors++;
            $display("FAIL last_write_wins: g=%0d required 9", g);
        end

        do_write(2'd3, 4'd15);
        sync_pe("sel3_sync");
        count_on(16, r, g, b);
        checks++;
        if (r !== 4 || g !== 9 || b !== 0) begin
            errors++;
            $display("FAIL sel3_ignored: r=%0d g=%0d b=%0d required 4/9/0", r, g, b);
        end
    endtask

    task automatic test_en_drop();
        sync_pe("en_sync");
        @(negedge clk);
        checks++;
        if (led[LED_R] !== 1'b1) begin
            errors++;
            $display("FAIL en_pre: led_r=%b required 1", led[LED_R]);
        end
        en[LED_R] = 1'b0;
        @(negedge clk);
        checks++;
        if (led[LED_R] !== 1'b0) begin
            errors++;
            $display("FAIL en_drop: led_r=%b required 0", led[LED_R]);
        end
        en[LED_R] = 1'b1;
    endtask

    task automatic test_blink();
        int zeros, ones;
        bit ok;
        do_write(2'd2, 4'd15);
        sync_pe("blink_sync");
        blink_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!led[LED_B]) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL blink_first_off: led_b stuck 1 required 0");
        end
        zeros = 1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (led[LED_B]) break;
            zeros++;
        end
        ones = 1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!led[LED_B]) break;
            ones++;
        end
        checks++;
        if (zeros !== 32 || ones !== 32) begin
            errors++;
            $display("FAIL blink_runs: off=%0d on=%0d required 32/32", zeros, ones);
        end
        blink_en = 1'b0;
        @(negedge clk);
        checks++;
        if (led[LED_B] !== 1'b1) begin
            errors++;
            $display("FAIL blink_drop: led_b=%b required 1", led[LED_B]);
        end
    endtask

    task automatic test_reset_mid();
        int r, g, b;
        sync_pe("mid_sync");
        repeat (7) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (led !== 3'b000 || period_end !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: led=%b pe=%b required 000/0", led, period_end);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        count_on(40, r, g, b);
        checks++;
        if (r + g + b !== 0) begin
            errors++;
            $display("FAIL mid_no_retain: r=%0d g=%0d b=%0d required 0/0/0", r, g, b);
        end
        do_write(2'd0, 4'd4);
        sync_pe("mid_rewrite_sync");
        count_on(16, r, g, b);
        checks++;
        if (r !== 4) begin
            errors++;
            $display("FAIL mid_rewrite: r=%0d required 4", r);
        end
    endtask

    initial begin
        test_reset();
        test_duty_r();
        test_full_zero();
        test_boundary();
        test_en_drop();
        test_blink();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
